// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots of {valid, ctrl, data}
// with stall/flush and saturating event counters for hazard-unit debug.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  bubble_count,
    input  logic              clr_counts
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  slot_valid;
    logic [CTRL_W-1:0] slot_ctrl [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];

    // Ctrl is zeroed with valid so a bubble can never carry RegWrite/MemWrite;
    // data is left alone on flush since nothing consumes it without valid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_valid[i] <= 1'b0;
                slot_ctrl[i]  <= '0;
                slot_data[i]  <= '0;
            end
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_valid[i] <= 1'b0;
                slot_ctrl[i]  <= '0;
            end
        end else if (!Stall) begin
            slot_valid[0] <= in_valid;
            slot_ctrl[0]  <= in_valid ? in_ctrl : '0;
            slot_data[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_ctrl[i]  <= slot_ctrl[i-1];
                slot_data[i]  <= slot_data[i-1];
            end
        end
    end

    assign out_valid = slot_valid[DEPTH-1];
    assign out_ctrl  = slot_ctrl[DEPTH-1];
    assign out_data  = slot_data[DEPTH-1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Flush outranks Stall, so a simultaneous pair counts only as a flush.
    always_ff @(posedge Clk) begin
        if (Rst || clr_counts) begin
            stall_count  <= '0;
            flush_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (Flush)
                flush_count <= sat_inc(flush_count);
            else if (Stall)
                stall_count <= sat_inc(stall_count);
            if (!slot_valid[DEPTH-1])
                bubble_count <= sat_inc(bubble_count);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 1..4) share one
// stimulus bus; each scenario resets and checks only its own instance.
module tb_pipe_stage_reg;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, in_valid, clr_counts;
    logic [7:0]  in_ctrl;
    logic [95:0] in_data;

    logic        v1, v2, v3, v4;
    logic [7:0]  c1, c2, c3, c4;
    logic [95:0] d1, d2, d3, d4;
    logic [15:0] sc1, fc1, bc1, sc3, fc3, bc3, sc4, fc4, bc4;
    logic [3:0]  sc2, fc2, bc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .DEPTH(1), .CNT_W(16)) u_d1 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v1), .out_ctrl(c1),
        .out_data(d1), .stall_count(sc1), .flush_count(fc1), .bubble_count(bc1),
        .clr_counts(clr_counts));

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .DEPTH(2), .CNT_W(4)) u_d2 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v2), .out_ctrl(c2),
        .out_data(d2), .stall_count(sc2), .flush_count(fc2), .bubble_count(bc2),
        .clr_counts(clr_counts));

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .DEPTH(3), .CNT_W(16)) u_d3 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v3), .out_ctrl(c3),
        .out_data(d3), .stall_count(sc3), .flush_count(fc3), .bubble_count(bc3),
        .clr_counts(clr_counts));

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .DEPTH(4), .CNT_W(16)) u_d4 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .in_valid(in_valid),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v4), .out_ctrl(c4),
        .out_data(d4), .stall_count(sc4), .flush_count(fc4), .bubble_count(bc4),
        .clr_counts(clr_counts));

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [95:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; clr_counts = 1'b0;
        drive(1'b0, 8'h00, 96'h0);
        step();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (v1 !== 1'b0 || c1 !== 8'h00 || d1 !== 96'h0) begin
            $display("FAIL reset_outputs: got v=%b c=%h d=%h want 0/00/0", v1, c1, d1); n_fail++;
        end
        n_checks++;
        if (sc1 !== 16'd0 || fc1 !== 16'd0 || bc1 !== 16'd0) begin
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", sc1, fc1, bc1); n_fail++;
        end
    endtask

    task automatic test_pass_through();
        do_reset();
        drive(1'b1, 8'hA5, 96'h1234);
        step();
        n_checks++;
        if (v1 !== 1'b1 || c1 !== 8'hA5 || d1 !== 96'h1234) begin
            $display("FAIL pass_capture: got v=%b c=%h d=%h want 1/a5/1234", v1, c1, d1); n_fail++;
        end
        drive(1'b0, 8'hA5, 96'h1234);
        step();
        n_checks++;
        if (v1 !== 1'b0 || c1 !== 8'h00 || d1 !== 96'h1234) begin
            $display("FAIL pass_bubble: got v=%b c=%h d=%h want 0/00/1234", v1, c1, d1); n_fail++;
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            if (e <= 3) drive(1'b1, 8'(e), 96'(e));
            else        drive(1'b0, 8'h00, 96'h0);
            step();
            n_checks++;
            if (e < 3) begin
                if (v3 !== 1'b0 || c3 !== 8'h00) begin
                    $display("FAIL lat_empty e%0d: got v=%b c=%h want 0/00", e, v3, c3); n_fail++;
                end
            end else begin
                if (v3 !== 1'b1 || c3 !== 8'(e-2) || d3 !== 96'(e-2)) begin
                    $display("FAIL lat_item e%0d: got v=%b c=%h d=%h want 1/%h/%h",
                             e, v3, c3, d3, 8'(e-2), 96'(e-2)); n_fail++;
                end
            end
            if (e == 2) begin
                n_checks++;
                if (bc3 !== 16'd2) begin
                    $display("FAIL lat_bubble_count: got %0d want 2", bc3); n_fail++;
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 8'h07, 96'h7); step();
        drive(1'b1, 8'h08, 96'h8); step();
        n_checks++;
        if (v2 !== 1'b1 || c2 !== 8'h07 || d2 !== 96'h7) begin
            $display("FAIL stall_preload: got v=%b c=%h d=%h want 1/07/7", v2, c2, d2); n_fail++;
        end
        Stall = 1'b1;
        drive(1'b1, 8'h09, 96'h9);
        for (int e = 0; e < 3; e++) begin
            step();
            n_checks++;
            if (v2 !== 1'b1 || c2 !== 8'h07 || d2 !== 96'h7) begin
                $display("FAIL stall_hold %0d: got v=%b c=%h d=%h want 1/07/7", e, v2, c2, d2); n_fail++;
            end
        end
        n_checks++;
        if (sc2 !== 4'd3) begin
            $display("FAIL stall_count: got %0d want 3", sc2); n_fail++;
        end
        Stall = 1'b0;
        drive(1'b0, 8'h00, 96'h0);
        step();
        n_checks++;
        if (v2 !== 1'b1 || c2 !== 8'h08 || d2 !== 96'h8) begin
            $display("FAIL stall_release: got v=%b c=%h d=%h want 1/08/8", v2, c2, d2); n_fail++;
        end
        step();
        n_checks++;
        if (v2 !== 1'b0 || c2 !== 8'h00) begin
            $display("FAIL stall_drop: got v=%b c=%h want 0/00", v2, c2); n_fail++;
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive(1'b1, 8'hFF, 96'hA1); step();
        drive(1'b1, 8'hFF, 96'hB2); step();
        Flush = 1'b1; Stall = 1'b1;
        drive(1'b1, 8'hFF, 96'hC3);
        step();
        Flush = 1'b0; Stall = 1'b0;
        n_checks++;
        if (v2 !== 1'b0 || c2 !== 8'h00 || d2 !== 96'hA1) begin
            $display("FAIL flush_out: got v=%b c=%h d=%h want 0/00/a1", v2, c2, d2); n_fail++;
        end
        n_checks++;
        if (fc2 !== 4'd1 || sc2 !== 4'd0) begin
            $display("FAIL flush_counts: got flush=%0d stall=%0d want 1/0", fc2, sc2); n_fail++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b0, 8'h00, 96'h0);
        Stall = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 14 || e == 15 || e == 20) begin
                n_checks++;
                if (sc2 !== 4'((e > 15) ? 15 : e)) begin
                    $display("FAIL sat_stall e%0d: got %0d want %0d", e, sc2, (e > 15) ? 15 : e); n_fail++;
                end
            end
        end
        clr_counts = 1'b1;
        step();
        clr_counts = 1'b0; Stall = 1'b0;
        n_checks++;
        if (sc2 !== 4'd0 || fc2 !== 4'd0 || bc2 !== 4'd0) begin
            $display("FAIL sat_clear: got %0d/%0d/%0d want 0/0/0", sc2, fc2, bc2); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 1; e <= 3; e++) begin
            drive(1'b1, 8'(8'h10 + e), 96'(e));
            step();
        end
        n_checks++;
        if (bc4 !== 16'd3) begin
            $display("FAIL mid_precount: got %0d want 3", bc4); n_fail++;
        end
        Rst = 1'b1; Flush = 1'b1; clr_counts = 1'b1;
        drive(1'b1, 8'h44, 96'h44);
        step();
        Rst = 1'b0; Flush = 1'b0; clr_counts = 1'b0;
        n_checks++;
        if (v4 !== 1'b0 || c4 !== 8'h00 || d4 !== 96'h0) begin
            $display("FAIL mid_outputs: got v=%b c=%h d=%h want 0/00/0", v4, c4, d4); n_fail++;
        end
        n_checks++;
        if (sc4 !== 16'd0 || fc4 !== 16'd0 || bc4 !== 16'd0) begin
            $display("FAIL mid_counters: got %0d/%0d/%0d want 0/0/0", sc4, fc4, bc4); n_fail++;
        end
        for (int e = 1; e <= 4; e++) begin
            if (e == 1) drive(1'b1, 8'h55, 96'h55);
            else        drive(1'b0, 8'h00, 96'h0);
            step();
            n_checks++;
            if (e < 4) begin
                if (v4 !== 1'b0 || c4 !== 8'h00) begin
                    $display("FAIL mid_resume_empty e%0d: got v=%b c=%h want 0/00", e, v4, c4); n_fail++;
                end
            end else if (v4 !== 1'b1 || c4 !== 8'h55 || d4 !== 96'h55) begin
                $display("FAIL mid_resume_item: got v=%b c=%h d=%h want 1/55/55", v4, c4, d4); n_fail++;
            end
        end
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; clr_counts = 1'b0;
        drive(1'b0, 8'h00, 96'h0);
        test_reset();
        test_pass_through();
        test_latency();
        test_stall();
        test_flush_stall();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
